// File: rtl/seg_param_digit_sequencer.sv
// Sequential digit generator for the 7-seg display: picks one effect parameter by SW mode,
// scales it and peels off decimal digits, all through a single shared restoring divider.
module seg_param_digit_sequencer #(
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [9:0]         SW,
  input  logic signed [15:0] gain,
  input  logic signed [31:0] threshold,
  input  logic [31:0]        tr_freq,
  input  logic [31:0]        ring_freq,
  input  logic [31:0]        echo_delay_time,
  input  logic [31:0]        echo_delay_volume,
  input  logic [31:0]        vib_freq,
  input  logic [31:0]        sb_delay_time,
  output logic [31:0]        num0,
  output logic [31:0]        num1,
  output logic [31:0]        num2,
  output logic [31:0]        num3,
  output logic [31:0]        num4,
  output logic [31:0]        num5,
  output logic               busy,
  output logic               update
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] SCALE  = 3'd2;
  localparam logic [2:0] DIGIT  = 3'd3;
  localparam logic [2:0] FORMAT = 3'd4;

  localparam logic [31:0] BLANK = 32'd10;
  localparam logic [31:0] DASH  = 32'd11;

  logic [2:0]  state;
  logic [3:0]  last_mode;
  logic [31:0] refresh_cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic [4:0]  bit_cnt;
  logic [2:0]  dig_idx;
  logic        div0;
  logic [31:0] val;
  logic [3:0]  d0, d1, d2, d3, d4;

  logic [31:0] lat_n, lat_d;
  logic [31:0] cur_dvsr;
  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] next_rem, next_quo;
  logic        tick, abort_run;
  logic [31:0] f0, f1, f2, f3, f4, f5;
  logic        unused_sw_hi;

  assign unused_sw_hi = ^SW[9:4];
  assign busy         = (state != IDLE);
  assign tick         = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
  assign abort_run    = (state != IDLE) && (state != LATCH) && (SW[3:0] != last_mode);

  function automatic logic [31:0] code(input logic [3:0] d);
    return {28'd0, d};
  endfunction

  always_comb begin
    lat_n = '0;
    lat_d = 32'd1;
    case (SW[3:0])
      4'd0: lat_n = threshold[31] ? 32'd0 : threshold;
      4'd1: lat_n = gain[15] ? 32'd0 : {16'd0, gain};
      4'd2: begin lat_n = 32'd97656;   lat_d = tr_freq;   end
      4'd3: begin lat_n = 32'd1562500; lat_d = ring_freq; end
      4'd4: begin lat_n = echo_delay_time * 32'd100; lat_d = 32'd48000; end
      4'd5: lat_n = echo_delay_volume;
      4'd6: begin lat_n = 32'd97656;   lat_d = vib_freq;  end
      4'd7: begin lat_n = sb_delay_time * 32'd100; lat_d = 32'd48000; end
      default: ;
    endcase
  end

  // One restoring-division step; the digit phase always divides by ten.
  always_comb begin
    cur_dvsr = (state == DIGIT) ? 32'd10 : dvsr;
    shifted  = {rem, quo[31]};
    diff     = shifted - {1'b0, cur_dvsr};
    ge       = (shifted >= {1'b0, cur_dvsr});
    next_rem = ge ? diff[31:0] : shifted[31:0];
    next_quo = {quo[30:0], ge};
  end

  always_comb begin
    f0 = BLANK; f1 = BLANK; f2 = BLANK; f3 = BLANK; f4 = BLANK; f5 = BLANK;
    if (last_mode <= 4'd7) begin
      f5 = code(last_mode);
      f4 = DASH;
      if (div0) begin
        f3 = DASH; f2 = DASH; f1 = DASH; f0 = DASH;
      end else begin
        case (last_mode)
          4'd0, 4'd3: begin
            if (val < 32'd10000) begin
              f3 = (d3 == 4'd0) ? BLANK : code(d3);
              f2 = (d2 == 4'd0 && d3 == 4'd0) ? BLANK : code(d2);
              f1 = code(d1);
              f0 = code(d0);
            end else begin
              f3 = code(d4);
              f2 = code(d3);
              f1 = DASH;
              f0 = DASH;
            end
          end
          4'd1, 4'd2, 4'd6: begin
            f1 = (d1 == 4'd0) ? BLANK : code(d1);
            f0 = code(d0);
          end
          4'd4, 4'd7: begin
            f2 = code(d2);
            f1 = code(d1);
            f0 = code(d0);
          end
          default: f0 = (val > 32'd9) ? 32'd9 : val;
        endcase
      end
    end
  end

  // Free-running refresh timebase; its tick only matters while idle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) refresh_cnt <= '0;
    else if (tick) refresh_cnt <= '0;
    else refresh_cnt <= refresh_cnt + 32'd1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_mode <= 4'hF;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= 32'd1;
      bit_cnt   <= '0;
      dig_idx   <= '0;
      div0      <= 1'b0;
      val       <= '0;
      d0 <= '0; d1 <= '0; d2 <= '0; d3 <= '0; d4 <= '0;
      num0 <= BLANK; num1 <= BLANK; num2 <= BLANK;
      num3 <= BLANK; num4 <= BLANK; num5 <= BLANK;
      update    <= 1'b0;
    end else begin
      update <= 1'b0;
      if (abort_run) begin
        state <= LATCH;
      end else begin
        case (state)
          IDLE: if (tick || SW[3:0] != last_mode) state <= LATCH;
          LATCH: begin
            last_mode <= SW[3:0];
            quo       <= lat_n;
            dvsr      <= lat_d;
            rem       <= '0;
            bit_cnt   <= '0;
            div0      <= (lat_d == 32'd0);
            state     <= SCALE;
          end
          SCALE: begin
            rem     <= next_rem;
            quo     <= next_quo;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              val     <= next_quo;
              rem     <= '0;
              dig_idx <= '0;
              state   <= DIGIT;
            end
          end
          // Each pass leaves the quotient in quo as the dividend for the next digit.
          DIGIT: begin
            rem     <= next_rem;
            quo     <= next_quo;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
              rem     <= '0;
              dig_idx <= dig_idx + 3'd1;
              case (dig_idx)
                3'd0: d0 <= next_rem[3:0];
                3'd1: d1 <= next_rem[3:0];
                3'd2: d2 <= next_rem[3:0];
                3'd3: d3 <= next_rem[3:0];
                default: begin
                  d4    <= (next_quo != 32'd0) ? 4'd9 : next_rem[3:0];
                  state <= FORMAT;
                end
              endcase
            end
          end
          FORMAT: begin
            num0   <= f0; num1 <= f1; num2 <= f2;
            num3   <= f3; num4 <= f4; num5 <= f5;
            update <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
